rr_mux_nbit: RTL and testbench
==============================

RR_MUX_NBIT -- requirements
Module: rr_mux_nbit

Interface
REQ-001 SHALL have parameter N, default 2, data width per channel in bits (N >= 1).
REQ-002 SHALL have parameter K, default 4, number of input channels (2 <= K <= 16).
REQ-003 SHALL have parameter SW, default 2, select/channel-index width; SW = ceil(log2 K) is required.
REQ-004 SHALL have port clk, input, 1, single clock, all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port mode, input, 1, 0 = fixed select via sel, 1 = round-robin arbitration.
REQ-007 SHALL have port sel, input, SW, channel select used in mode 0.
REQ-008 SHALL have port in_data, input, K*N, channel i at bits [i*N +: N].
REQ-009 SHALL have port in_valid, input, K, per-channel valid.
REQ-010 SHALL have port in_ready, output, K, per-channel ready (combinational).
REQ-011 SHALL have port out_data, output, N, registered output word.
REQ-012 SHALL have port out_valid, output, 1, out_data holds a word.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts the word.
REQ-014 SHALL have port out_ch, output, SW, index of the channel that supplied out_data.

Function
REQ-015 SHALL define load enable L = !reset && (!out_valid || out_ready).
REQ-016 SHALL, in mode 0, grant channel g = sel when L, sel < K, and in_valid[sel] are all true; there is no grant otherwise.
REQ-017 SHALL, in mode 1, grant the first channel with in_valid set, searching ptr+1, ptr+2, ... modulo K, when L is true.
REQ-018 SHALL drive in_ready[g] = 1 for the granted channel only; all other in_ready bits are 0, and in_ready is at most one-hot.
REQ-019 SHALL, on a clock edge with a grant, load out_data <= in_data[g], out_ch <= g, out_valid <= 1.
REQ-020 SHALL, on a clock edge with L true and no grant, set out_valid <= 0 and hold out_data and out_ch.
REQ-021 SHALL hold out_data, out_ch, and out_valid stable while out_valid = 1 and out_ready = 0 (backpressure); in_ready is all 0 in that case.
REQ-022 SHALL have a latency of 1 cycle from input handshake to out_valid, and sustain 1 word per cycle when out_ready is held high.
REQ-023 SHALL update ptr <= g on each mode-1 grant; mode-0 grants leave ptr unchanged.
REQ-024 SHALL apply a mode or sel change at the next load decision, with no flush or loss of the held output word.
REQ-025 SHALL treat the wrap-around case (ptr = K-1) as a search starting at channel 0.
REQ-026 SHALL, with a single valid channel in mode 1, grant that channel every cycle with no idle bubble.

Reset
REQ-027 SHALL, while reset is high, force out_valid = 0, out_data = 0, out_ch = 0, ptr = K-1, and in_ready = all 0, independent of clk.
REQ-028 SHALL drop a word held in the output register when reset is asserted mid-operation; no partial handshake is completed.
REQ-029 SHALL allow the first grant on the first rising edge after reset deasserts, with the mode-1 search starting at channel 0.

Verification (N=2, K=4, SW=2)
REQ-030 Mode 0: sel=2, in_valid=0100, ch2 data=11, out_ready=1 -> in_ready=0100; next edge: out_data=11, out_ch=2, out_valid=1.
REQ-031 Mode 1 fairness: all in_valid=1111, data ch i = i, out_ready=1 from reset -> out_ch sequence 0,1,2,3,0 on consecutive cycles; out_data matches out_ch.
REQ-032 Backpressure: out_valid=1, out_data=01, out_ready=0 for 3 cycles with new inputs valid -> out_data stays 01, in_ready=0000; on out_ready=1 the next word loads on that edge.
REQ-033 Empty/invalid select: mode 0, sel=1, in_valid=1101 -> in_ready=0000, and out_valid falls to 0 after the pending word is popped.
REQ-034 Reset mid-operation: out_valid=1 with a word held, reset pulsed asynchronously between edges -> out_valid=0, out_data=00 immediately; after release, the mode-1 grant with in_valid=1111 is ch0.
REQ-035 Mode switch: mode 1 with ptr=1, switch to mode 0 with sel=3, then back to mode 1 -> a ch3 grant occurs, and the next mode-1 grant with in_valid=1111 is ch2 (ptr unchanged by the mode-0 grant).

Source files
------------

// File: rtl/rr_mux_nbit.sv
// ---------------------------------------------------------------------------
// rr_mux_nbit
//   K-channel, N-bit multiplexer with a single registered output slot.
//   The granted channel is either chosen directly by sel (mode = 0) or by a
//   round-robin search that starts just after the last round-robin winner
//   (mode = 1). One word per cycle is sustained while out_ready stays high.
//
// Parameters
//   N   data width per channel
//   K   number of input channels (2..16)
//   SW  channel index width, ceil(log2 K)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   mode       0 = fixed select via sel, 1 = round-robin
//   sel        channel select used in mode 0
//   in_data    channel i occupies bits [i*N +: N]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, combinational, at most one-hot
//   out_data   registered output word
//   out_valid  out_data holds a word
//   out_ready  downstream accepts the word
//   out_ch     index of the channel that supplied out_data
// ---------------------------------------------------------------------------
module rr_mux_nbit #(
    parameter int N  = 2,
    parameter int K  = 4,
    parameter int SW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    input  logic [K*N-1:0]  in_data,
    input  logic [K-1:0]    in_valid,
    output logic [K-1:0]    in_ready,
    output logic [N-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_ch
);

    // Last round-robin winner; K-1 after reset so the first search starts at 0.
    logic [SW-1:0] ptr;

    logic          load;
    logic          fix_ok;
    logic          rr_found;
    logic [SW-1:0] rr_idx;
    logic [SW:0]   cand;
    logic          grant;
    logic [SW-1:0] grant_ch;
    logic [N-1:0]  grant_data;

    // Output slot can take a new word when empty or being drained this cycle.
    always_comb begin
        load = 1'b0;
        if (!reset && (!out_valid || out_ready)) begin
            load = 1'b1;
        end else begin
            load = 1'b0;
        end
    end

    // Fixed-select qualification; a select beyond the last channel never grants.
    always_comb begin
        fix_ok = 1'b0;
        if ({1'b0, sel} < (SW+1)'(K)) begin
            fix_ok = in_valid[sel];
        end else begin
            fix_ok = 1'b0;
        end
    end

    // Round-robin search over ptr+1 .. ptr+K modulo K; first valid channel wins.
    // The candidate is kept one bit wider so ptr+i never overflows before the wrap.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int i = 1; i <= K; i++) begin
            cand = {1'b0, ptr} + (SW+1)'(i);
            if (cand >= (SW+1)'(K)) begin
                cand = cand - (SW+1)'(K);
            end else begin
                cand = cand;
            end
            if (!rr_found && in_valid[cand[SW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[SW-1:0];
            end else begin
                rr_found = rr_found;
            end
        end
    end

    // Grant decision for this cycle, only made when the output slot can load.
    always_comb begin
        grant    = 1'b0;
        grant_ch = '0;
        if (load) begin
            if (mode) begin
                grant    = rr_found;
                grant_ch = rr_idx;
            end else begin
                grant    = fix_ok;
                grant_ch = sel;
            end
        end else begin
            grant    = 1'b0;
            grant_ch = '0;
        end
    end

    // One-hot ready for the granted channel and selection of its data word.
    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < K; i++) begin
            if (grant && (grant_ch == SW'(i))) begin
                in_ready[i] = 1'b1;
                grant_data  = in_data[i*N +: N];
            end else begin
                in_ready[i] = 1'b0;
            end
        end
    end

    // Output register and round-robin pointer; only mode-1 grants move ptr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SW'(K-1);
        end else if (load) begin
            if (grant) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant_ch;
                if (mode) begin
                    ptr <= grant_ch;
                end else begin
                    ptr <= ptr;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_rr_mux_nbit.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_nbit
//   Self-checking bench for rr_mux_nbit (N=2, K=4, SW=2): directed scenarios
//   with literal expectations followed by randomized traffic compared every
//   cycle against a behavioural model of the grant/output rules.
// ---------------------------------------------------------------------------
module tb_rr_mux_nbit;

    localparam int N  = 2;
    localparam int K  = 4;
    localparam int SW = 2;

    logic             clk;
    logic             reset;
    logic             mode;
    logic [SW-1:0]    sel;
    logic [K*N-1:0]   in_data;
    logic [K-1:0]     in_valid;
    logic [K-1:0]     in_ready;
    logic [N-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic [SW-1:0]    out_ch;

    int checks = 0;
    int errors = 0;
    logic cmp_on = 1'b0;

    rr_mux_nbit #(.N(N), .K(K), .SW(SW)) dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .sel      (sel),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ch   (out_ch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid = 1'b0;
    logic [N-1:0] m_data = '0;
    logic [SW-1:0] m_ch  = '0;
    int          m_ptr   = K-1;
    int          m_g;
    logic [K-1:0] exp_ready;

    // Channel that is handed over this cycle, or -1 when nobody is.
    function automatic int model_grant(input logic rst, input logic md, input logic [SW-1:0] s,
                                       input logic [K-1:0] v, input int p,
                                       input logic ov, input logic ordy);
        int c;
        if (rst || (ov && !ordy)) return -1;
        if (!md) return v[s] ? int'(s) : -1;
        for (int k = 1; k <= K; k++) begin
            c = (p + k) % K;
            if (v[c[SW-1:0]]) return c;
        end
        return -1;
    endfunction

    always_comb m_g = model_grant(reset, mode, sel, in_valid, m_ptr, m_valid, out_ready);

    always_comb begin
        exp_ready = '0;
        if (m_g >= 0) exp_ready[m_g[SW-1:0]] = 1'b1;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ch    <= '0;
            m_ptr   <= K-1;
        end else if (!m_valid || out_ready) begin
            if (m_g >= 0) begin
                m_valid <= 1'b1;
                m_data  <= N'(in_data >> (N*m_g));
                m_ch    <= SW'(m_g);
                if (mode) m_ptr <= m_g;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_in_ready",  32'(in_ready),  32'(exp_ready));
            chk("model_out_valid", 32'(out_valid), 32'(m_valid));
            chk("model_out_data",  32'(out_data),  32'(m_data));
            chk("model_out_ch",    32'(out_ch),    32'(m_ch));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        mode      = 1'b0;
        sel       = 2'd0;
        in_data   = 8'h00;
        in_valid  = 4'hF;
        out_ready = 1'b1;

        cyc();
        cmp_on = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_ch",    32'(out_ch),    32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);

        // Mode 0, sel=2, only ch2 valid, ch2 data = 11.
        reset    = 1'b0;
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b0100;
        in_data  = 8'h30;
        #3;
        chk("m0_in_ready", 32'(in_ready), 32'h4);
        cyc();
        chk("m0_out_data",  32'(out_data),  32'd3);
        chk("m0_out_ch",    32'(out_ch),    32'd2);
        chk("m0_out_valid", 32'(out_valid), 32'd1);

        // Asynchronous reset while a word is held.
        reset    = 1'b1;
        mode     = 1'b1;
        in_valid = 4'hF;
        in_data  = 8'hE4;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data",  32'(out_data),  32'd0);
        chk("arst_out_ch",    32'(out_ch),    32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd0);
        reset = 1'b0;
        #2;
        chk("rr_first_ready", 32'(in_ready), 32'h1);

        // Fairness: 0,1,2,3,0 with data equal to channel index.
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rr_seq_ch",    32'(out_ch),    32'(i % 4));
            chk("rr_seq_data",  32'(out_data),  32'(i % 4));
            chk("rr_seq_valid", 32'(out_valid), 32'd1);
        end

        // Backpressure holding word 01.
        cyc();
        chk("bp_load_data", 32'(out_data), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom());
            #3;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            cyc();
            chk("bp_hold_data",  32'(out_data),  32'd1);
            chk("bp_hold_ch",    32'(out_ch),    32'd1);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        in_data   = 8'hE4;
        #3;
        chk("bp_release_ready", 32'(in_ready), 32'h4);
        cyc();
        chk("bp_release_data", 32'(out_data), 32'd2);
        chk("bp_release_ch",   32'(out_ch),   32'd2);

        // Mode switch: get ptr=1, mode-0 grant of ch3, then mode 1 continues at ch2.
        in_valid = 4'b0010;
        cyc();
        chk("ms_ptr1_ch", 32'(out_ch), 32'd1);
        mode     = 1'b0;
        sel      = 2'd3;
        in_valid = 4'hF;
        cyc();
        chk("ms_m0_ch",   32'(out_ch),   32'd3);
        chk("ms_m0_data", 32'(out_data), 32'd3);
        mode = 1'b1;
        cyc();
        chk("ms_m1_ch", 32'(out_ch), 32'd2);

        // Invalid select: ch1 not valid.
        mode     = 1'b0;
        sel      = 2'd1;
        in_valid = 4'b1101;
        #3;
        chk("empty_in_ready", 32'(in_ready), 32'd0);
        cyc();
        chk("empty_out_valid", 32'(out_valid), 32'd0);

        // Single valid channel in mode 1: no bubbles.
        mode     = 1'b1;
        in_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("single_ch",    32'(out_ch),    32'd2);
            chk("single_valid", 32'(out_valid), 32'd1);
        end

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            mode      = 1'($urandom());
            sel       = 2'($urandom());
            in_data   = 8'($urandom());
            in_valid  = 4'($urandom());
            out_ready = (($urandom() % 4) != 0);
            if (($urandom() % 150) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            cyc();
        end

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
